// File: rtl/spi_mem_pkg.sv
// spi_mem_pkg
// Shared definitions for the SPI memory bridge: the serial FSM state
// encoding and the 2-bit command codes carried in the first two bits of
// every frame.
package spi_mem_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CMD      = 3'd1,
        ST_PAYLOAD  = 3'd2,
        ST_RD_WAIT  = 3'd3,
        ST_RD_SHIFT = 3'd4
    } state_t;

    localparam logic [1:0] CMD_SET_WADDR = 2'b00;
    localparam logic [1:0] CMD_WRITE     = 2'b01;
    localparam logic [1:0] CMD_SET_RADDR = 2'b10;
    localparam logic [1:0] CMD_READ      = 2'b11;

endpackage

// File: rtl/spi_mem_array.sv
// spi_mem_array
// Single-port word memory with synchronous read. Addresses at or beyond
// MEM_DEPTH are treated as holes: writes are dropped and reads return zero.
// Ports:
//   clk  - clock, rising edge
//   we   - write enable; when low the addressed word is read into dout
//   addr - word address (ADDR_W bits, may exceed MEM_DEPTH-1)
//   din  - write data
//   dout - registered read data
module spi_mem_array #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 8,
    parameter int MEM_DEPTH = 256
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout
);
    import spi_mem_pkg::*;

    localparam int              IDX_W   = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(MEM_DEPTH);

    logic [DATA_W-1:0] mem [MEM_DEPTH];
    logic              in_range;
    logic [IDX_W-1:0]  idx;

    assign in_range = ({1'b0, addr} < DEPTH_L);
    // Upper address bits only matter for the range test; the index itself
    // fits in IDX_W bits whenever the address is in range.
    assign idx      = addr[IDX_W-1:0];

    // Contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            if (in_range) mem[idx] <= din;
        end else begin
            dout <= in_range ? mem[idx] : '0;
        end
    end

endmodule

// File: rtl/spi_mem_bridge.sv
// spi_mem_bridge
// SPI-style slave that gives a serial master access to a small memory.
// Each frame starts with a 2-bit command (MSB first) followed either by a
// DATA_W-bit payload (set write address, write data, set read address) or by
// a one-edge read latency and DATA_W bits shifted out on MISO (read data).
// Frames stream back-to-back while SS_n stays low; SS_n high mid-frame
// aborts the frame and pulses frame_err.
// Ports:
//   clk       - system and serial bit clock, rising edge
//   rst_n     - asynchronous active-low reset
//   SS_n      - slave select, active low
//   MOSI      - serial data in, MSB first
//   MISO      - registered serial data out, 0 when no read bit is shown
//   frame_err - one-cycle pulse after an aborted frame
module spi_mem_bridge #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 8,
    parameter int MEM_DEPTH = 256
) (
    input  logic clk,
    input  logic rst_n,
    input  logic SS_n,
    input  logic MOSI,
    output logic MISO,
    output logic frame_err
);
    import spi_mem_pkg::*;

    localparam int               CNT_W     = (DATA_W > 2) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(DATA_W - 1);
    localparam logic [ADDR_W:0]  LAST_ADDR = (ADDR_W+1)'(MEM_DEPTH - 1);

    state_t            state;
    logic              cmd_first;   // first command bit of the frame captured
    logic [1:0]        cmd_reg;
    logic [CNT_W-1:0]  bit_cnt;
    logic [DATA_W-2:0] rx_shift;
    logic [DATA_W-1:0] tx_shift;
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W-1:0] rd_addr;
    logic              miso_q;
    logic              frame_err_q;

    logic [DATA_W-1:0] payload;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_dout;

    // Out-of-range addresses also wrap to zero on increment.
    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
        if ({1'b0, a} >= LAST_ADDR) return '0;
        return a + ADDR_W'(1);
    endfunction

    // The payload is complete on the edge that samples its last bit.
    assign payload = {rx_shift, MOSI};

    always_comb begin
        mem_we   = 1'b0;
        mem_addr = wr_addr;
        if (!SS_n && state == ST_PAYLOAD && cmd_reg == CMD_WRITE && bit_cnt == LAST_BIT)
            mem_we = 1'b1;
        // Read is issued on the second command edge so the word is ready to
        // load into the transmit shifter on the next edge.
        if (!SS_n && state == ST_CMD && cmd_first && {cmd_reg[0], MOSI} == CMD_READ)
            mem_addr = rd_addr;
    end

    spi_mem_array #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .MEM_DEPTH (MEM_DEPTH)
    ) u_array (
        .clk  (clk),
        .we   (mem_we),
        .addr (mem_addr),
        .din  (payload),
        .dout (mem_dout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            cmd_first   <= 1'b0;
            cmd_reg     <= '0;
            bit_cnt     <= '0;
            rx_shift    <= '0;
            tx_shift    <= '0;
            wr_addr     <= '0;
            rd_addr     <= '0;
            miso_q      <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            frame_err_q <= 1'b0;
            miso_q      <= 1'b0;
            if (SS_n) begin
                // CMD with no bit captured is the gap right after a completed
                // frame, so deselecting there is a clean end, not an abort.
                if (state != ST_IDLE && !(state == ST_CMD && !cmd_first))
                    frame_err_q <= 1'b1;
                state     <= ST_IDLE;
                cmd_first <= 1'b0;
                bit_cnt   <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        cmd_reg[0] <= MOSI;
                        cmd_first  <= 1'b1;
                        state      <= ST_CMD;
                    end
                    ST_CMD: begin
                        if (!cmd_first) begin
                            cmd_reg[0] <= MOSI;
                            cmd_first  <= 1'b1;
                        end else begin
                            cmd_reg   <= {cmd_reg[0], MOSI};
                            cmd_first <= 1'b0;
                            bit_cnt   <= '0;
                            if ({cmd_reg[0], MOSI} == CMD_READ) begin
                                rd_addr <= next_addr(rd_addr);
                                state   <= ST_RD_WAIT;
                            end else begin
                                state   <= ST_PAYLOAD;
                            end
                        end
                    end
                    ST_PAYLOAD: begin
                        rx_shift <= payload[DATA_W-2:0];
                        if (bit_cnt == LAST_BIT) begin
                            case (cmd_reg)
                                CMD_SET_WADDR: wr_addr <= payload[ADDR_W-1:0];
                                CMD_WRITE:     wr_addr <= next_addr(wr_addr);
                                CMD_SET_RADDR: rd_addr <= payload[ADDR_W-1:0];
                                default: ;
                            endcase
                            bit_cnt <= '0;
                            state   <= ST_CMD;
                        end else begin
                            bit_cnt <= bit_cnt + CNT_W'(1);
                        end
                    end
                    ST_RD_WAIT: begin
                        miso_q   <= mem_dout[DATA_W-1];
                        tx_shift <= {mem_dout[DATA_W-2:0], 1'b0};
                        bit_cnt  <= '0;
                        state    <= ST_RD_SHIFT;
                    end
                    ST_RD_SHIFT: begin
                        // Last edge of a read frame only returns MISO to 0.
                        if (bit_cnt == LAST_BIT) begin
                            bit_cnt <= '0;
                            state   <= ST_CMD;
                        end else begin
                            miso_q   <= tx_shift[DATA_W-1];
                            tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
                            bit_cnt  <= bit_cnt + CNT_W'(1);
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    assign MISO      = miso_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_spi_mem_bridge.sv
// tb_spi_mem_bridge
// Drives two bridges from the same serial stream: one with default
// parameters and one with ADDR_W=4, MEM_DEPTH=10. A frame-level model keeps
// per-instance memory, known-cell flags and the two address pointers, and
// every MISO bit of a read frame is compared against it.
module tb_spi_mem_bridge;

    logic clk;
    logic rst_n;
    logic SS_n;
    logic MOSI;
    logic miso_a, ferr_a, miso_b, ferr_b;

    int n_checks = 0;
    int n_errors = 0;

    spi_mem_bridge dut_a (
        .clk(clk), .rst_n(rst_n), .SS_n(SS_n), .MOSI(MOSI),
        .MISO(miso_a), .frame_err(ferr_a)
    );

    spi_mem_bridge #(.DATA_W(8), .ADDR_W(4), .MEM_DEPTH(10)) dut_b (
        .clk(clk), .rst_n(rst_n), .SS_n(SS_n), .MOSI(MOSI),
        .MISO(miso_b), .frame_err(ferr_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model, index 0 = dut_a, 1 = dut_b
    localparam int DEPTH [2] = '{256, 10};
    localparam int MASK  [2] = '{255, 15};
    logic [7:0] m_mem   [2][256];
    bit         m_known [2][256];
    int         m_wa [2];
    int         m_ra [2];

    function automatic int inc_addr(input int d, input int a);
        return (a + 1 >= DEPTH[d]) ? 0 : a + 1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one bit, let the DUT take the rising edge, return at the
    // following falling edge where outputs are sampled.
    task automatic drive_edge(input logic b);
        MOSI = b;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic frame(input logic [1:0] cmd, input logic [7:0] pay);
        logic [7:0] exp_w [2];
        bit         kn    [2];
        SS_n = 1'b0;
        drive_edge(cmd[1]);
        drive_edge(cmd[0]);
        if (cmd != 2'b11) begin
            for (int i = 7; i >= 0; i--) drive_edge(pay[i]);
            for (int d = 0; d < 2; d++) begin
                case (cmd)
                    2'b00: m_wa[d] = int'(pay) & MASK[d];
                    2'b01: begin
                        if (m_wa[d] < DEPTH[d]) begin
                            m_mem[d][m_wa[d]]   = pay;
                            m_known[d][m_wa[d]] = 1'b1;
                        end
                        m_wa[d] = inc_addr(d, m_wa[d]);
                    end
                    default: m_ra[d] = int'(pay) & MASK[d];
                endcase
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                if (m_ra[d] < DEPTH[d]) begin
                    exp_w[d] = m_mem[d][m_ra[d]];
                    kn[d]    = m_known[d][m_ra[d]];
                end else begin
                    exp_w[d] = 8'h00;
                    kn[d]    = 1'b1;
                end
                m_ra[d] = inc_addr(d, m_ra[d]);
            end
            chk("rd_head_a", miso_a, 0);
            chk("rd_head_b", miso_b, 0);
            for (int i = 0; i < 8; i++) begin
                drive_edge(1'($urandom));
                if (kn[0]) chk("rd_bit_a", miso_a, exp_w[0][7-i]);
                if (kn[1]) chk("rd_bit_b", miso_b, exp_w[1][7-i]);
            end
            drive_edge(1'($urandom));
            chk("rd_tail_a", miso_a, 0);
            chk("rd_tail_b", miso_b, 0);
        end
    endtask

    task automatic end_frame();
        SS_n = 1'b1;
        drive_edge(1'b0);
        chk("clean_end_ferr_a", ferr_a, 0);
        chk("clean_end_ferr_b", ferr_b, 0);
    endtask

    // Send n edges of a frame (command then payload bits), then deselect.
    task automatic abort_frame(input logic [1:0] cmd, input logic [7:0] pay, input int n);
        logic [9:0] bits;
        bits = {cmd, pay};
        SS_n = 1'b0;
        for (int i = 0; i < n; i++) drive_edge(bits[9-i]);
        if (cmd == 2'b11 && n >= 2)
            for (int d = 0; d < 2; d++) m_ra[d] = inc_addr(d, m_ra[d]);
        SS_n = 1'b1;
        drive_edge(1'b0);
        chk("abort_ferr_a", ferr_a, 1);
        chk("abort_ferr_b", ferr_b, 1);
        drive_edge(1'b0);
        chk("abort_ferr_clr_a", ferr_a, 0);
        chk("abort_ferr_clr_b", ferr_b, 0);
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_wa[d] = 0;
            m_ra[d] = 0;
        end
    endtask

    initial begin
        int start, cnt;
        for (int d = 0; d < 2; d++)
            for (int a = 0; a < 256; a++) m_known[d][a] = 1'b0;
        model_reset();

        // Reset held with the bus active
        rst_n = 1'b0;
        SS_n  = 1'b0;
        MOSI  = 1'b0;
        #1;
        chk("rst_miso_a", miso_a, 0);
        chk("rst_ferr_a", ferr_a, 0);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            drive_edge(~MOSI);
            chk("rst_miso_a", miso_a, 0);
            chk("rst_ferr_a", ferr_a, 0);
            chk("rst_miso_b", miso_b, 0);
            chk("rst_ferr_b", ferr_b, 0);
        end
        rst_n = 1'b1;

        // Burst write then read back
        frame(2'b00, 8'h10);
        frame(2'b01, 8'hA5);
        frame(2'b01, 8'h5A);
        frame(2'b10, 8'h10);
        frame(2'b11, 8'h00);
        frame(2'b11, 8'h00);
        end_frame();

        // Address wrap
        frame(2'b00, 8'hFF);
        frame(2'b01, 8'h11);
        frame(2'b01, 8'h22);
        frame(2'b10, 8'hFF);
        frame(2'b11, 8'h00);
        frame(2'b11, 8'h00);
        frame(2'b10, 8'h00);
        frame(2'b11, 8'h00);
        end_frame();

        // Abort of a write leaves memory untouched
        frame(2'b00, 8'h20);
        frame(2'b01, 8'h3E);
        frame(2'b01, 8'hC1);
        end_frame();
        frame(2'b00, 8'h20);
        abort_frame(2'b01, 8'h77, 5);
        frame(2'b10, 8'h20);
        frame(2'b11, 8'h00);
        end_frame();

        // Abort of a read keeps the rd_addr increment
        frame(2'b10, 8'h20);
        abort_frame(2'b11, 8'h00, 4);
        frame(2'b11, 8'h00);
        end_frame();

        // Reset during edge 6 of a read frame
        frame(2'b00, 8'h40);
        frame(2'b01, 8'hFF);
        frame(2'b10, 8'h40);
        for (int d = 0; d < 2; d++) m_ra[d] = inc_addr(d, m_ra[d]);
        drive_edge(1'b1);
        drive_edge(1'b1);
        drive_edge(1'b0);
        drive_edge(1'b0);
        drive_edge(1'b0);
        chk("mid_read_bit_a", miso_a, 1);
        chk("mid_read_bit_b", miso_b, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_miso_a", miso_a, 0);
        chk("async_rst_miso_b", miso_b, 0);
        @(negedge clk);
        @(negedge clk);
        SS_n  = 1'b1;
        rst_n = 1'b1;
        model_reset();
        drive_edge(1'b0);
        chk("post_rst_ferr_a", ferr_a, 0);
        frame(2'b11, 8'h00);
        end_frame();

        // Small-memory instance: wrap at 10 and holes at 10..15
        frame(2'b00, 8'h09);
        frame(2'b01, 8'h3C);
        frame(2'b01, 8'hC3);
        frame(2'b00, 8'h0C);
        frame(2'b01, 8'h55);
        frame(2'b10, 8'h09);
        frame(2'b11, 8'h00);
        frame(2'b11, 8'h00);
        frame(2'b10, 8'h0C);
        frame(2'b11, 8'h00);
        frame(2'b10, 8'h00);
        frame(2'b11, 8'h00);
        end_frame();

        // Randomized bursts with occasional aborts
        for (int it = 0; it < 10; it++) begin
            start = $urandom_range(0, 255);
            cnt   = $urandom_range(1, 5);
            frame(2'b00, 8'(start));
            for (int k = 0; k < cnt; k++) frame(2'b01, 8'($urandom));
            if ($urandom_range(0, 2) == 0)
                abort_frame(2'($urandom), 8'($urandom), $urandom_range(1, 9));
            frame(2'b10, 8'(start));
            for (int k = 0; k < cnt; k++) frame(2'b11, 8'($urandom));
            end_frame();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
